rx_word_uart_bridge: RTL and testbench



---
 rtl/rx_word_uart_bridge.sv | 195 +++++++++++++++++++
 tb/tb_rx_word_uart_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_uart_bridge.sv
// rx_word_uart_bridge: buffers 32-bit payload words in a small FIFO and sends
// each word LSB byte first as UART 8N1 frames.
// Optional build macro: UART_SYNC_MARKER_EN. When defined, a 0xA5 sync byte
// precedes every word, so each word is sent as 5 bytes instead of 4.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   data, valid - payload word and its one-cycle qualifier; data[7:0] is sent first
//   uart_tx     - serial line, idle high
//   busy        - a word is being sent or the FIFO is not empty
//   fifo_level  - number of words stored
//   drop        - one-cycle pulse when an incoming word is discarded
//   drop_cnt    - saturating count of discarded words
module rx_word_uart_bridge #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 115200,
   parameter int unsigned FIFO_AW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        data,
   input  logic               valid,
   output logic               uart_tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               drop,
   output logic [7:0]         drop_cnt
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned DEPTH        = 1 << FIFO_AW;
   localparam int unsigned LVL_W        = FIFO_AW + 1;
`ifdef UART_SYNC_MARKER_EN
   localparam logic [2:0]  LAST_BYTE    = 3'd4;
   localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
`else
   localparam logic [2:0]  LAST_BYTE    = 3'd3;
`endif

   // Bit timing needs at least two clocks per bit.
   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("rx_word_uart_bridge: CLK_FREQ/BAUD must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t               r_state;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_drop;
   logic [7:0]           r_drop_cnt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2:0]           r_bit_idx;
   logic [2:0]           r_byte_idx;
   logic [31:0]          r_shift;
   logic [31:0]          r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wr_ptr;
   logic [FIFO_AW-1:0]   r_rd_ptr;
   logic [LVL_W-1:0]     r_level;

   logic                 w_pop;
   logic                 w_push;
   logic                 w_last_tick;
   logic                 w_word_done;
   logic [LVL_W-1:0]     w_level_nxt;
   logic [7:0]           w_byte;

   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
   assign w_push      = valid && ((r_level != LVL_W'(DEPTH)) || w_pop);
   assign w_last_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_word_done = (r_state == S_STOP) && w_last_tick && (r_byte_idx == LAST_BYTE);

`ifdef UART_SYNC_MARKER_EN
   assign w_byte = (r_byte_idx == 3'd0) ? SYNC_BYTE : r_shift[7:0];
`else
   assign w_byte = r_shift[7:0];
`endif

   // Next FIFO occupancy.
   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - LVL_W'(1);
      end
   end

   // FIFO storage, no reset needed: only read behind the write pointer.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data;
      end
   end

   // FIFO bookkeeping, status outputs and the serialiser FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_drop     <= 1'b0;
         r_drop_cnt <= '0;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_shift    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
      end else begin
         r_level <= w_level_nxt;
         r_busy  <= (r_state != S_IDLE && !w_word_done) || w_pop || (w_level_nxt != '0);
         r_drop  <= valid && !w_push;
         if (valid && !w_push && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         end

         // The line follows the state of the cycle just ending, so it lags one clock.
         case (r_state)
            S_IDLE: begin
               r_tx  <= 1'b1;
               r_cnt <= '0;
               if (w_pop) begin
                  r_shift    <= r_mem[r_rd_ptr];
                  r_byte_idx <= '0;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               r_tx <= 1'b0;
               if (w_last_tick) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               r_tx <= w_byte[r_bit_idx];
               if (w_last_tick) begin
                  r_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               r_tx <= 1'b1;
               if (w_last_tick) begin
                  r_cnt <= '0;
                  if (r_byte_idx == LAST_BYTE) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_byte_idx <= r_byte_idx + 3'd1;
                     r_state    <= S_START;
`ifdef UART_SYNC_MARKER_EN
                     // The sync byte is not in the shift register; keep data[7:0] in place.
                     if (r_byte_idx != 3'd0) begin
                        r_shift <= {8'h00, r_shift[31:8]};
                     end
`else
                     r_shift <= {8'h00, r_shift[31:8]};
`endif
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign uart_tx    = r_tx;
   assign busy       = r_busy;
   assign fifo_level = r_level;
   assign drop       = r_drop;
   assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_rx_word_uart_bridge.sv
// Testbench for rx_word_uart_bridge: random and directed word traffic checked
// cycle by cycle against a queue-based reference model of the bridge.
module tb_rx_word_uart_bridge;

   localparam int unsigned CPB   = 10;
   localparam int unsigned DEPTH = 4;
`ifdef UART_SYNC_MARKER_EN
   localparam int unsigned OFF   = 1;
`else
   localparam int unsigned OFF   = 0;
`endif
   localparam int unsigned BYTES = 4 + OFF;
   localparam int unsigned TOTAL = BYTES * 10 * CPB;

   logic        clk;
   logic        rst_n;
   logic [31:0] data;
   logic        valid;
   logic        uart_tx;
   logic        busy;
   logic [2:0]  fifo_level;
   logic        drop;
   logic [7:0]  drop_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: queued words, cycles left in the word being sent.
   logic [31:0] m_q[$];
   logic [31:0] m_word;
   int unsigned m_rem;
   logic        m_drop;
   int unsigned m_drop_cnt;

   logic [2:0]  peak;
   int unsigned n_drop_seen;

   rx_word_uart_bridge #(
      .CLK_FREQ(50000000),
      .BAUD    (5000000),
      .FIFO_AW (2)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .valid     (valid),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .fifo_level(fifo_level),
      .drop      (drop),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_word     = '0;
      m_rem      = 0;
      m_drop     = 1'b0;
      m_drop_cnt = 0;
   endtask

   // One clock edge of the bridge seen as a word queue feeding a fixed-length transmitter.
   task automatic model_edge(input logic v, input logic [31:0] d);
      logic pop;
      logic push;
      pop    = (m_rem == 0) && (m_q.size() != 0);
      push   = v && ((m_q.size() < DEPTH) || pop);
      m_drop = v && !push;
      if (m_drop && m_drop_cnt != 255) m_drop_cnt++;
      if (pop) begin
         m_word = m_q.pop_front();
         m_rem  = TOTAL;
      end else if (m_rem != 0) begin
         m_rem--;
      end
      if (push) m_q.push_back(d);
   endtask

   // Expected line level: frames start one clock after the pop edge.
   function automatic logic exp_tx();
      int unsigned t;
      int unsigned bi;
      int unsigned pos;
      logic [31:0] w;
      logic [7:0]  b;
      if (m_rem == 0 || m_rem == TOTAL) return 1'b1;
      t   = TOTAL - m_rem - 1;
      bi  = t / (10 * CPB);
      pos = (t % (10 * CPB)) / CPB;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      if (OFF == 1 && bi == 0) begin
         b = 8'hA5;
      end else begin
         w = m_word >> (8 * (bi - OFF));
         b = w[7:0];
      end
      return b[pos-1];
   endfunction

   task automatic check_all();
      check_eq("uart_tx",    32'(uart_tx),    32'(exp_tx()));
      check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      check_eq("busy",       32'(busy),       32'((m_rem != 0) || (m_q.size() != 0)));
      check_eq("drop",       32'(drop),       32'(m_drop));
      check_eq("drop_cnt",   32'(drop_cnt),   32'(m_drop_cnt));
   endtask

   // Drive at negedge, advance model at posedge, compare at the next negedge.
   task automatic step(input logic v, input logic [31:0] d);
      valid = v;
      data  = d;
      @(posedge clk);
      if (rst_n) model_edge(v, d);
      else       model_reset();
      @(negedge clk);
      check_all();
      if (fifo_level > peak) peak = fifo_level;
      if (drop) n_drop_seen++;
   endtask

   task automatic drain(input int unsigned max_cyc);
      int unsigned n;
      n = 0;
      while ((m_rem != 0 || m_q.size() != 0) && n < max_cyc) begin
         step(1'b0, '0);
         n++;
      end
      check_eq("drain_timeout", 32'(n < max_cyc), 32'd1);
      repeat (3) step(1'b0, '0);
   endtask

   initial begin
      int unsigned n;
      rst_n = 1'b0;
      valid = 1'b0;
      data  = '0;
      peak  = '0;
      n_drop_seen = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      step(1'b0, '0);

      // Single words.
      step(1'b1, 32'h44332211);
      drain(TOTAL + 20);
      step(1'b1, 32'h00000000);
      drain(TOTAL + 20);

      // Burst of five fills the FIFO without drops.
      peak = '0;
      for (int i = 0; i < 5; i++) step(1'b1, $urandom);
      check_eq("burst_peak", 32'(peak), 32'd4);
      drain(6 * TOTAL);
      check_eq("burst_drop_cnt", 32'(drop_cnt), 32'd0);

      // Overflow: seven in a row, last two dropped.
      n_drop_seen = 0;
      for (int i = 0; i < 7; i++) step(1'b1, $urandom);
      drain(6 * TOTAL);
      check_eq("ovf_drop_pulses", 32'(n_drop_seen), 32'd2);
      check_eq("ovf_drop_cnt", 32'(drop_cnt), 32'd2);

      // Push into a full FIFO on the same edge as the pop.
      for (int i = 0; i < 5; i++) step(1'b1, $urandom);
      n = 0;
      while (m_rem != 0 && n < TOTAL + 10) begin
         step(1'b0, '0);
         n++;
      end
      check_eq("simul_setup_level", 32'(fifo_level), 32'd4);
      step(1'b1, 32'hCAFEF00D);
      check_eq("simul_level", 32'(fifo_level), 32'd4);
      check_eq("simul_drop", 32'(drop), 32'd0);
      drain(6 * TOTAL);

      // Random sparse traffic with occasional bursts.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, $urandom);
      end
      drain(6 * TOTAL);

      // Drop counter saturation.
      for (int i = 0; i < 300; i++) step(1'b1, $urandom);
      check_eq("drop_sat", 32'(drop_cnt), 32'd255);
      drain(6 * TOTAL);

      // Reset during a data bit of byte 2 with another word still queued.
      step(1'b1, 32'h12345678);
      step(1'b1, 32'h9ABCDEF0);
      check_eq("rst_setup_pop", 32'(m_rem == TOTAL), 32'd1);
      repeat (246) step(1'b0, '0);
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_tx", 32'(uart_tx), 32'd1);
      check_eq("rst_async_level", 32'(fifo_level), 32'd0);
      check_eq("rst_async_busy", 32'(busy), 32'd0);
      model_reset();
      repeat (3) step(1'b0, '0);
      rst_n = 1'b1;
      step(1'b0, '0);
      step(1'b1, 32'hDEADBEEF);
      drain(TOTAL + 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
